// File: rtl/fir_mul_pkg.sv
// Shared widths, mode encodings and saturation bounds for the FIR multiplier
// datapath and anything downstream that narrows its products.
package fir_mul_pkg;

    localparam bit MODE_UNSIGNED = 1'b0;
    localparam bit MODE_SIGNED   = 1'b1;
    localparam bit ROUND_OFF     = 1'b0;
    localparam bit ROUND_ON      = 1'b1;
    localparam bit SAT_WRAP      = 1'b0;
    localparam bit SAT_CLAMP     = 1'b1;

    // Bound constants are built this wide and then cut down to the result width.
    localparam int unsigned BOUND_W = 128;

    function automatic int unsigned prod_width(input int unsigned w0, input int unsigned w1);
        return w0 + w1;
    endfunction

    function automatic logic [BOUND_W-1:0] sat_max(input int unsigned w, input bit sgn);
        logic [BOUND_W-1:0] one;
        one = BOUND_W'(1);
        return sgn ? (one << (w - 1)) - one : (one << w) - one;
    endfunction

    function automatic logic [BOUND_W-1:0] sat_min(input int unsigned w, input bit sgn);
        logic [BOUND_W-1:0] one;
        one = BOUND_W'(1);
        return sgn ? ~((one << (w - 1)) - one) : '0;
    endfunction

endpackage

// File: rtl/fir_mul_narrow.sv
// Combinational round / shift / saturate-or-wrap stage that turns a full
// product into the result width and flags any loss of magnitude.
module fir_mul_narrow
    import fir_mul_pkg::*;
#(
    parameter int unsigned IN_W     = 64,
    parameter int unsigned OUT_W    = 32,
    parameter int unsigned SHIFT    = 0,
    parameter bit          SIGNED   = MODE_SIGNED,
    parameter bit          ROUND    = ROUND_OFF,
    parameter bit          SATURATE = SAT_WRAP
) (
    input  logic [IN_W-1:0]  prod,
    output logic [OUT_W-1:0] res_c,
    output logic             ovf_c
);

    // One guard bit so the rounding increment can never carry out.
    localparam int unsigned EXT_W   = IN_W + 1;
    localparam int unsigned RND_POS = (SHIFT == 0) ? 0 : SHIFT - 1;
    localparam logic [EXT_W-1:0] RND_INC =
        (ROUND == ROUND_ON && SHIFT != 0) ? EXT_W'(1) << RND_POS : '0;

    logic [EXT_W-1:0] ext;
    logic [EXT_W-1:0] rnd;
    logic [EXT_W-1:0] shd;

    always_comb begin
        ext = {SIGNED & prod[IN_W-1], prod};
        rnd = ext + RND_INC;
        if (SIGNED == MODE_SIGNED) begin
            shd = EXT_W'($signed(rnd) >>> SHIFT);
        end else begin
            shd = rnd >> SHIFT;
        end
    end

    if (OUT_W >= EXT_W) begin : g_extend
        logic signed [EXT_W-1:0] shd_s;
        assign shd_s = shd;
        always_comb begin
            if (SIGNED == MODE_SIGNED) begin
                res_c = OUT_W'(shd_s);
            end else begin
                res_c = OUT_W'(shd);
            end
        end
        assign ovf_c = 1'b0;
    end else begin : g_narrow
        logic ovf_raw;
        // Overflow: the discarded top bits are not a clean sign/zero extension.
        always_comb begin
            if (SIGNED == MODE_SIGNED) begin
                ovf_raw = !((&shd[EXT_W-1:OUT_W-1]) || !(|shd[EXT_W-1:OUT_W-1]));
            end else begin
                ovf_raw = |shd[EXT_W-1:OUT_W];
            end
            res_c = shd[OUT_W-1:0];
            ovf_c = ovf_raw;
            if (SATURATE == SAT_CLAMP && ovf_raw) begin
                if (SIGNED == MODE_SIGNED && shd[EXT_W-1]) begin
                    res_c = OUT_W'(sat_min(OUT_W, SIGNED));
                end else begin
                    res_c = OUT_W'(sat_max(OUT_W, SIGNED));
                end
            end
        end
    end

endmodule

// File: rtl/fir_mul_pipe.sv
// Pipelined FIR multiplier: operand register, retimable product stages and a
// registered narrowed result, with clock-enable stall and valid tracking.
module fir_mul_pipe
    import fir_mul_pkg::*;
#(
    parameter int          ID         = 1,
    parameter int unsigned NUM_STAGE  = 3,
    parameter int unsigned din0_WIDTH = 32,
    parameter int unsigned din1_WIDTH = 32,
    parameter int unsigned dout_WIDTH = 32,
    parameter bit          SIGNED     = MODE_SIGNED,
    parameter int unsigned SHIFT      = 0,
    parameter bit          ROUND      = ROUND_OFF,
    parameter bit          SATURATE   = SAT_WRAP
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);

    localparam int unsigned PW = prod_width(din0_WIDTH, din1_WIDTH);

    if (NUM_STAGE < 1 || NUM_STAGE > 8) begin : g_bad_num_stage
        $error("fir_mul_pipe %0d: NUM_STAGE must be 1..8", ID);
    end

    function automatic logic [PW-1:0] mul_full(input logic [din0_WIDTH-1:0] a,
                                               input logic [din1_WIDTH-1:0] b);
        if (SIGNED == MODE_SIGNED) begin
            return PW'($signed(a)) * PW'($signed(b));
        end else begin
            return PW'(a) * PW'(b);
        end
    endfunction

    logic [NUM_STAGE-1:0] vld;
    logic [NUM_STAGE:0]   vchain;
    logic [PW-1:0]        prod_last;
    logic [dout_WIDTH-1:0] res_c;
    logic                 ovf_c;

    // vchain[k] is the valid bit entering stage k+1; the top slot is dropped on shift.
    assign vchain    = {vld, in_valid};
    assign out_valid = vld[NUM_STAGE-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
        end else if (ce) begin
            vld <= vchain[NUM_STAGE-1:0];
        end
    end

    if (NUM_STAGE == 1) begin : g_comb
        assign prod_last = mul_full(din0, din1);
    end else begin : g_pipe
        logic [din0_WIDTH-1:0] a_q;
        logic [din1_WIDTH-1:0] b_q;
        logic [PW-1:0]         prod_c;

        always_ff @(posedge clk) begin
            if (ce) begin
                a_q <= din0;
                b_q <= din1;
            end
        end

        assign prod_c = mul_full(a_q, b_q);

        if (NUM_STAGE == 2) begin : g_direct
            assign prod_last = prod_c;
        end else begin : g_mid
            logic [PW-1:0] p_q [NUM_STAGE-2];
            always_ff @(posedge clk) begin
                if (ce) begin
                    p_q[0] <= prod_c;
                    for (int unsigned i = 1; i < NUM_STAGE - 2; i++) begin
                        p_q[i] <= p_q[i-1];
                    end
                end
            end
            assign prod_last = p_q[NUM_STAGE-3];
        end
    end

    fir_mul_narrow #(
        .IN_W    (PW),
        .OUT_W   (dout_WIDTH),
        .SHIFT   (SHIFT),
        .SIGNED  (SIGNED),
        .ROUND   (ROUND),
        .SATURATE(SATURATE)
    ) u_narrow (
        .prod (prod_last),
        .res_c(res_c),
        .ovf_c(ovf_c)
    );

    // Result only moves when a real sample reaches the last stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout <= '0;
            ovf  <= 1'b0;
        end else if (ce && vchain[NUM_STAGE-1]) begin
            dout <= res_c;
            ovf  <= ovf_c;
        end
    end

endmodule

// File: doc/fir_mul_pipe.md
Name: fir_mul_pipe

Overview:
Parametrised, pipelined multiplier for the FIR datapath. It is the successor to the single-cycle combinational multiplier primitive and adds the following:
- configurable latency and signedness
- clock-enable stall and valid tracking
- optional post-product arithmetic shift, rounding and saturation, with an overflow flag

It sits between the coefficient/sample fetch and the accumulator, so long products can be retimed across NUM_STAGE registers.

Parameters:
ID, 1, instance identifier; no functional effect
NUM_STAGE, 3, latency in clk cycles with ce held high; legal range 1..8
din0_WIDTH, 32, width of operand 0
din1_WIDTH, 32, width of operand 1
dout_WIDTH, 32, width of result
SIGNED, 1, 1 = two's-complement operands and result; 0 = unsigned
SHIFT, 0, right shift applied to the full product before narrowing; range 0..din0_WIDTH+din1_WIDTH-1
ROUND, 0, 1 = round-half-up: add 2^(SHIFT-1) before the shift; ignored when SHIFT=0
SATURATE, 0, 1 = clamp to the dout range; 0 = wrap (truncate)

Ports:
clk  in  1  clock; all registers update on the rising edge
reset  in  1  synchronous, active-high reset
ce  in  1  clock enable; 0 freezes every register, including valid flags
in_valid  in  1  din0/din1 hold a sample this cycle
din0  in  din0_WIDTH  operand 0
din1  in  din1_WIDTH  operand 1
out_valid  out  1  dout/ovf hold a new result this cycle
dout  out  dout_WIDTH  narrowed result
ovf  out  1  result was clamped (SATURATE=1) or wrapped (SATURATE=0)

Behaviour:
- Reset: every valid bit, out_valid, dout and ovf go to 0. Reset takes priority over ce. In-flight samples are discarded and never appear at the output.
- Pipeline: a valid shift register of depth NUM_STAGE runs alongside the data stages.
  - Stage 1 registers the operands.
  - The product is formed and carried through the middle stages (retimable).
  - The final stage registers the post-processed result.
  - NUM_STAGE=1 means one output register behind the whole combinational path.
- Latency: a sample accepted with in_valid=1 on a ce=1 edge appears with out_valid=1 exactly NUM_STAGE ce=1 edges later. Throughput is 1 sample per ce=1 cycle.
- ce=0: all state holds. out_valid, dout and ovf keep their values and are not re-asserted as new results. Samples presented while ce=0 are ignored.
- in_valid=0: a bubble propagates. dout and ovf update only when a valid sample reaches the final stage; otherwise they hold the last result while out_valid=0.
- Arithmetic:
  - Full product P is din0_WIDTH+din1_WIDTH bits, signed or unsigned per SIGNED.
  - Rounding is performed in P+1 bits, so it cannot overflow.
  - The shift is arithmetic when SIGNED=1 and logical otherwise.
- Narrowing with SATURATE=1:
  - A value above the max representable gives max (signed 2^(dout_WIDTH-1)-1, unsigned 2^dout_WIDTH-1) with ovf=1.
  - A value below the min gives the signed min -2^(dout_WIDTH-1) with ovf=1.
  - Otherwise the value passes through with ovf=0.
- Narrowing with SATURATE=0: keep the low dout_WIDTH bits. ovf=1 when the discarded high bits are not a pure sign/zero extension.
- Extreme operands: with SIGNED=1, min×min gives a positive P that fits and is handled by the rules above.
- dout_WIDTH > shifted product width: sign-extend (SIGNED=1) or zero-extend (SIGNED=0); ovf stays 0.
- Simultaneous reset and ce=1 with in_valid=1: reset wins and the sample is dropped.

Decomposition:
- Shared package fir_mul_pkg holds:
  - the localparam helper for product width
  - saturation bound constants as functions of width and signedness
  - the mode encoding constants (SIGNED, ROUND, SATURATE)
- One sub-module, fir_mul_narrow: purely combinational round/shift/saturate/ovf logic. It is instantiated before the final register and is reusable by the accumulator.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1, ce=1, then release → out_valid=0, dout=0, ovf=0 throughout, and no spurious out_valid.
- Defaults, din0=-3, din1=7, single valid → after 3 edges out_valid=1 for one cycle, dout=0xFFFFFFEB, ovf=0.
- Streaming, defaults: products 1×2, 3×4, 5×6, 7×8 on consecutive cycles → out_valid high cycles 3–6 with dout 2, 12, 30, 56, in order.
- Stall: same stream with ce=0 for 2 cycles after the second input → latency stretches to 5 for in-flight samples; outputs 2, 12, 30, 56 with none lost or duplicated; dout/ovf held during the stall.
- Saturation (din 16-bit, dout_WIDTH=16, SATURATE=1):
  - 300×300 → 32767, ovf=1
  - -300×300 → -32768, ovf=1
  - 100×100 → 10000, ovf=0
  - Same cases with SATURATE=0: 300×300 → 0x5F90 (24464), ovf=1.
- Rounding (ROUND=1, SHIFT=4, 16-bit, signed):
  - 3×3 → 1
  - 3×2 → 0
  - -3×3 → -1
  - Reset asserted while these 3 are in flight → none emerge.
